// File: rtl/rx_band_pass_fir_ctrl_if.sv
// Bus bundle for the band-pass FIR sequencer: sample stream in, coefficient
// BRAM read port, filtered result out. The master side is the environment
// (sample source plus coefficient BRAM); the slave side is the sequencer.
interface rx_band_pass_fir_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 41,
  parameter int AW     = 9
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_in;
  logic                     ready;
  logic                     coef_enb;
  logic [AW-1:0]            coef_addrb;
  logic signed [DATA_W-1:0] coef_dob;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  acc_out;
  logic signed [DATA_W-1:0] filt_out;
  logic                     overrun;

  modport master (
    output sample_valid, sample_in, coef_dob,
    input  ready, coef_enb, coef_addrb, out_valid, acc_out, filt_out, overrun
  );

  modport slave (
    input  sample_valid, sample_in, coef_dob,
    output ready, coef_enb, coef_addrb, out_valid, acc_out, filt_out, overrun
  );
endinterface

// File: rtl/rx_band_pass_fir_ctrl.sv
// rx_band_pass_fir_ctrl: sequencer for the receive-chain band-pass FIR.
// Each accepted sample is written into a circular history RAM, then all
// N_TAPS coefficients are fetched from the external BRAM and multiplied
// against history[(base - t) mod N_TAPS]; the sum is emitted once per sample.
module rx_band_pass_fir_ctrl #(
  parameter int N_TAPS    = 512,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 41,
  parameter int OUT_SHIFT = 15
) (
  input  logic                   clk,
  input  logic                   rrx_rst,
  rx_band_pass_fir_ctrl_if.slave bus
);
  localparam int AW     = $clog2(N_TAPS);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RUN, S_DRAIN} state_t;

  // Widen a sample/coefficient to product width keeping its sign.
  function automatic logic signed [PROD_W-1:0] sext_prod(input logic signed [DATA_W-1:0] x);
    return {{(PROD_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // Widen a product to accumulator width keeping its sign.
  function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Arithmetic shift then clamp into the signed DATA_W output range.
  // The shifted value fits iff bits [ACC_W-1:DATA_W-1] are all equal.
  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> OUT_SHIFT;
    if (!s[ACC_W-1] && (|s[ACC_W-2:DATA_W-1]))
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (s[ACC_W-1] && !(&s[ACC_W-2:DATA_W-1]))
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return s[DATA_W-1:0];
  endfunction

  // Control state
  state_t                   state_q, state_d;
  logic [AW:0]              clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            hist_raddr_q, hist_raddr_d;
  logic                     ready_q, ready_d;
  logic                     coef_enb_q, coef_enb_d;
  logic [AW-1:0]            coef_addrb_q, coef_addrb_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic signed [DATA_W-1:0] filt_out_q, filt_out_d;
  logic                     overrun_q, overrun_d;

  // History RAM write port (combinational decode of the control state)
  logic                     hist_we;
  logic [AW-1:0]            hist_waddr;
  logic signed [DATA_W-1:0] hist_wdata;
  logic                     acc_clr;

  // Datapath pipeline
  logic                     vld_p0, vld_p1, vld_p2, vld_p3;
  logic signed [DATA_W-1:0] hist_p1;
  logic signed [DATA_W-1:0] hist_p2, coef_p2;
  logic signed [PROD_W-1:0] prod_p3;
  logic signed [ACC_W-1:0]  acc_p4;

  logic signed [DATA_W-1:0] hist_mem [N_TAPS];

  // A tap is in flight at issue whenever the coefficient port is enabled.
  assign vld_p0 = coef_enb_q;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    hist_raddr_d = hist_raddr_q;
    ready_d      = ready_q;
    coef_enb_d   = coef_enb_q;
    coef_addrb_d = coef_addrb_q;
    out_valid_d  = 1'b0;
    acc_out_d    = acc_out_q;
    filt_out_d   = filt_out_q;
    overrun_d    = overrun_q | (bus.sample_valid & (state_q != S_IDLE));
    acc_clr      = 1'b0;
    hist_we      = 1'b0;
    hist_waddr   = '0;
    hist_wdata   = '0;

    unique case (state_q)
      S_CLEAR: begin
        // One zero written per cycle; the extra count bit marks completion.
        if (clr_cnt_q[AW]) begin
          state_d  = S_IDLE;
          ready_d  = 1'b1;
          wr_ptr_d = '0;
        end else begin
          hist_we    = 1'b1;
          hist_waddr = clr_cnt_q[AW-1:0];
          clr_cnt_d  = clr_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.sample_valid) begin
          hist_we      = 1'b1;
          hist_waddr   = wr_ptr_q;
          hist_wdata   = bus.sample_in;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          hist_raddr_d = wr_ptr_q;
          acc_clr      = 1'b1;
          state_d      = S_RUN;
          ready_d      = 1'b0;
          coef_enb_d   = 1'b1;
          coef_addrb_d = '0;
        end
      end
      S_RUN: begin
        // Coefficient address walks up while the history address walks back.
        if (coef_addrb_q == AW'(N_TAPS - 1)) begin
          state_d      = S_DRAIN;
          coef_enb_d   = 1'b0;
          coef_addrb_d = '0;
        end else begin
          coef_addrb_d = coef_addrb_q + 1'b1;
          hist_raddr_d = hist_raddr_q - 1'b1;
        end
      end
      S_DRAIN: begin
        // Once the pipeline is empty the accumulator holds the final sum.
        if (!(vld_p1 | vld_p2 | vld_p3)) begin
          state_d     = S_IDLE;
          ready_d     = 1'b1;
          out_valid_d = 1'b1;
          acc_out_d   = acc_p4;
          filt_out_d  = sat_out(acc_p4);
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Sequencer registers; reset restarts the history clear and zeroes outputs.
  always_ff @(posedge clk) begin
    if (rrx_rst) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      hist_raddr_q <= '0;
      ready_q      <= 1'b0;
      coef_enb_q   <= 1'b0;
      coef_addrb_q <= '0;
      out_valid_q  <= 1'b0;
      acc_out_q    <= '0;
      filt_out_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      hist_raddr_q <= hist_raddr_d;
      ready_q      <= ready_d;
      coef_enb_q   <= coef_enb_d;
      coef_addrb_q <= coef_addrb_d;
      out_valid_q  <= out_valid_d;
      acc_out_q    <= acc_out_d;
      filt_out_q   <= filt_out_d;
      overrun_q    <= overrun_d;
    end
  end

  // History RAM: writes only in CLEAR/IDLE, reads only while taps issue.
  always_ff @(posedge clk) begin
    if (hist_we && !rrx_rst)
      hist_mem[hist_waddr] <= hist_wdata;
    // p0 -> p1: history read, same latency as the coefficient BRAM
    if (vld_p0)
      hist_p1 <= hist_mem[hist_raddr_q];
  end

  // Tap-valid chain travelling alongside the datapath.
  always_ff @(posedge clk) begin
    if (rrx_rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Multiply-accumulate datapath.
  always_ff @(posedge clk) begin
    // p1 -> p2: align BRAM data with the history word
    coef_p2 <= bus.coef_dob;
    hist_p2 <= hist_p1;
    // p2 -> p3: full-precision signed product
    prod_p3 <= sext_prod(coef_p2) * sext_prod(hist_p2);
    // p3 -> p4: accumulate, cleared when a new sample is accepted
    if (acc_clr)
      acc_p4 <= '0;
    else if (vld_p3)
      acc_p4 <= acc_p4 + sext_acc(prod_p3);
  end

  assign bus.ready      = ready_q;
  assign bus.coef_enb   = coef_enb_q;
  assign bus.coef_addrb = coef_addrb_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.acc_out    = acc_out_q;
  assign bus.filt_out   = filt_out_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_rx_band_pass_fir_ctrl.sv
// Self-checking bench for rx_band_pass_fir_ctrl. Expected results come from a
// direct convolution over the list of accepted samples and a coefficient
// BRAM model that answers one cycle after each enabled read.
module tb_rx_band_pass_fir_ctrl;
  localparam int N_TAPS = 512;

  logic clk;
  logic rrx_rst;

  rx_band_pass_fir_ctrl_if #(.DATA_W(16), .ACC_W(41), .AW(9)) bus ();

  rx_band_pass_fir_ctrl #(
    .N_TAPS(N_TAPS), .DATA_W(16), .ACC_W(41), .OUT_SHIFT(15)
  ) dut (
    .clk     (clk),
    .rrx_rst (rrx_rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic signed [15:0] coef_mem [N_TAPS];
  longint xs[$];
  longint last_exp_acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient BRAM: one-cycle read latency.
  always @(posedge clk)
    if (bus.coef_enb) bus.coef_dob <= coef_mem[bus.coef_addrb];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_coefs(input int mode);
    for (int k = 0; k < N_TAPS; k++) begin
      case (mode)
        0:       coef_mem[k] = 16'sh7FFF;
        1:       coef_mem[k] = 16'sh8000;
        2:       coef_mem[k] = 16'(k + 1);
        default: coef_mem[k] = 16'($urandom);
      endcase
    end
  endtask

  // Apply reset, check reset values, then watch the clear phase.
  task automatic check_clear();
    int bad;
    rrx_rst = 1'b1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready",      64'(bus.ready),      64'sd0);
    chk("rst_coef_enb",   64'(bus.coef_enb),   64'sd0);
    chk("rst_coef_addrb", 64'(bus.coef_addrb), 64'sd0);
    chk("rst_out_valid",  64'(bus.out_valid),  64'sd0);
    chk("rst_acc_out",    64'(bus.acc_out),    64'sd0);
    chk("rst_filt_out",   64'(bus.filt_out),   64'sd0);
    chk("rst_overrun",    64'(bus.overrun),    64'sd0);
    rrx_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || bus.coef_enb !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.acc_out !== 41'sd0 || bus.filt_out !== 16'sd0)
        bad++;
    end
    chk("clear_quiet_cycles_bad", 64'(bad), 64'sd0);
    @(negedge clk);
    chk("ready_after_clear", 64'(bus.ready), 64'sd1);
    xs.delete();
    last_exp_acc = 0;
  endtask

  // Idle cycles between results: outputs held, ready stays up.
  task automatic idle_gap(input int g);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      chk("gap_out_valid_low", 64'(bus.out_valid), 64'sd0);
      chk("gap_ready",         64'(bus.ready),     64'sd1);
      chk("gap_acc_held",      64'(bus.acc_out),   64'(last_exp_acc));
    end
  endtask

  // Offer one sample, follow the tap sweep, check the result. A stray
  // sample_valid is injected k cycles after the accept when inject_at >= 0.
  task automatic run_sample(input logic signed [15:0] x, input int inject_at);
    longint exp_acc, exp_filt;
    int n, k, bad;
    logic [8:0] ea;
    chk("ready_before_accept", 64'(bus.ready), 64'sd1);
    xs.push_back(longint'(x));
    n = xs.size() - 1;
    exp_acc = 0;
    for (int t = 0; t < N_TAPS && t <= n; t++)
      exp_acc += longint'(coef_mem[t]) * xs[n - t];
    exp_filt = exp_acc >>> 15;
    if (exp_filt > 32767) exp_filt = 32767;
    else if (exp_filt < -32768) exp_filt = -32768;
    last_exp_acc = exp_acc;

    bus.sample_valid = 1'b1;
    bus.sample_in = x;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bad = 0;
    k = 0;
    while (k < 600 && bus.out_valid !== 1'b1) begin
      ea = (k <= 511) ? k[8:0] : 9'd0;
      if (bus.coef_enb !== (k <= 511) || bus.coef_addrb !== ea || bus.ready !== 1'b0)
        bad++;
      if (k == inject_at) begin
        bus.sample_valid = 1'b1;
        bus.sample_in = 16'($urandom);
      end else begin
        bus.sample_valid = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.sample_valid = 1'b0;
    chk("sweep_cycles_bad",     64'(bad),          64'sd0);
    chk("latency",              64'(k),            64'sd516);
    chk("ready_with_out_valid", 64'(bus.ready),    64'sd1);
    chk("acc_out",              64'(bus.acc_out),  64'(exp_acc));
    chk("filt_out",             64'(bus.filt_out), 64'(exp_filt));
  endtask

  initial begin
    int bad;
    rrx_rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    set_coefs(0);
    repeat (3) @(negedge clk);

    // Reset and clear phase
    check_clear();

    // Full-scale coefficients, single sample then saturation
    run_sample(16'sh7FFF, -1);
    chk("single_acc_literal",  64'(bus.acc_out),  64'sd1073676289);
    chk("single_filt_literal", 64'(bus.filt_out), 64'sd32766);
    idle_gap(2);
    run_sample(16'sh7FFF, -1);
    chk("satpos_acc_literal",  64'(bus.acc_out),  64'sd2147352578);
    chk("satpos_filt_literal", 64'(bus.filt_out), 64'sd32767);

    // Most-negative coefficients, accepted in the out_valid cycle
    set_coefs(1);
    run_sample(16'sh7FFF, -1);
    chk("satneg_acc_literal",  64'(bus.acc_out),  -64'sd3221127168);
    chk("satneg_filt_literal", 64'(bus.filt_out), -64'sd32768);
    idle_gap(1);

    // Impulse response: coef[k] = k+1 exposes history indexing
    check_clear();
    set_coefs(2);
    for (int n = 0; n < 8; n++) begin
      run_sample((n == 0) ? 16'sd1 : 16'sd0, -1);
      chk("impulse_acc_literal", 64'(bus.acc_out), 64'(n + 1));
      idle_gap(n % 3);
    end

    // Random coefficients and samples with random gaps
    set_coefs(3);
    for (int r = 0; r < 20; r++) begin
      run_sample(16'($urandom), -1);
      idle_gap(int'($urandom_range(0, 3)));
    end

    // Overrun: stray sample mid-run is dropped and flagged, flag is sticky
    chk("overrun_before", 64'(bus.overrun), 64'sd0);
    run_sample(16'($urandom), 100);
    chk("overrun_set", 64'(bus.overrun), 64'sd1);
    idle_gap(1);
    run_sample(16'($urandom), -1);
    chk("overrun_sticky", 64'(bus.overrun), 64'sd1);
    idle_gap(1);

    // Reset 200 cycles into a run aborts it
    chk("abort_ready", 64'(bus.ready), 64'sd1);
    bus.sample_valid = 1'b1;
    bus.sample_in = 16'sh1234;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 199; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("abort_in_run_state", 64'(bus.coef_enb), 64'sd1);
    chk("abort_no_out_valid", 64'(bad), 64'sd0);
    check_clear();

    // Operation after the abort uses a freshly cleared history
    run_sample(16'sh0101, -1);
    chk("post_abort_overrun", 64'(bus.overrun), 64'sd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_band_pass_fir_ctrl.md
# rx_band_pass_fir_ctrl

Sequencer for the 512-tap band-pass FIR in the receive chain. For each accepted input sample it stores the sample in an internal 512-entry circular history buffer. It then walks all 512 coefficient addresses of the external band-pass coefficient BRAM read port, multiply-accumulates coefficient × history, and emits one filtered output. It sits between the receive sample stream and the downstream correlator and owns the coefficient BRAM read port exclusively.

## Interface
- N_TAPS, 512, number of taps and history depth (power of two).
- DATA_W, 16, sample and coefficient width, signed two's complement.
- ACC_W, 41, accumulator width (2·DATA_W + log2(N_TAPS)).
- OUT_SHIFT, 15, arithmetic right shift applied before output saturation.

- clk  in  1  clock
- rrx_rst  in  1  reset, synchronous, active-high
- sample_valid  in  1  input sample strobe, one cycle per sample
- sample_in  in  DATA_W  signed input sample
- ready  out  1  high when a sample_valid will be accepted
- coef_enb  out  1  coefficient BRAM read enable
- coef_addrb  out  9  coefficient BRAM read address
- coef_dob  in  DATA_W  coefficient BRAM read data, valid 1 cycle after address/enable
- out_valid  out  1  one-cycle strobe, result valid
- acc_out  out  ACC_W  full-precision signed sum, held until the next out_valid
- filt_out  out  DATA_W  saturated (acc >>> OUT_SHIFT), held until the next out_valid
- overrun  out  1  sticky: a sample_valid arrived while busy; cleared only by reset

## Operation
- States: CLEAR, IDLE, RUN, DRAIN.
- CLEAR (entered on reset):
  - Writes 0 to history addresses 0..511, one per cycle, for 512 cycles.
  - Then goes to IDLE with wr_ptr = 0.
  - ready = 0 throughout.
- IDLE:
  - ready = 1.
  - On sample_valid: write sample_in to history[wr_ptr], latch base = wr_ptr, wr_ptr += 1 (mod 512), clear accumulator, go to RUN.
- RUN: tap t = 0..511, one per cycle.
  - coef_enb = 1, coef_addrb = t.
  - History read address = (base − t) mod 512.
  - After t = 511 is issued, go to DRAIN.
- Pipeline:
  - Issue.
  - BRAM/history data (1-cycle read latency).
  - Registered signed product, 2·DATA_W bits.
  - acc += sign-extended product.
- DRAIN: waits for the last product to accumulate, then:
  - pulses out_valid;
  - loads acc_out and filt_out;
  - returns to IDLE.
- filt_out = acc >>> OUT_SHIFT, clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- The accumulator never wraps for legal inputs; no overflow handling is required.
- sample_valid while not in IDLE:
  - the sample is dropped and not written, so the history is unchanged;
  - overrun is set;
  - the ongoing computation is unaffected.
- Outside RUN: coef_enb = 0, coef_addrb = 0.
- History buffer is inferred RAM with no reset. It is never read and written in the same cycle.

## Timing
- Reset values:
  - ready = 0, coef_enb = 0, coef_addrb = 0;
  - out_valid = 0, acc_out = 0, filt_out = 0, overrun = 0;
  - wr_ptr = 0, state = CLEAR.
- Reset has priority over every other input.
- ready rises 512 cycles after the reset-release edge (first edge with rrx_rst = 0).
- Sample accepted on edge E0:
  - ready = 0 and coef_enb = 1 with coef_addrb = 0 after E0;
  - coef_addrb = 511 after E0+511;
  - coef_enb = 0 after E0+512;
  - last accumulate on edge E0+515;
  - out_valid = 1 for exactly one cycle after E0+516;
  - ready = 1 in that same cycle.
- Minimum spacing between accepted samples is 517 cycles.
- A sample_valid coinciding with the out_valid cycle is accepted.
- Reset mid-RUN/DRAIN:
  - aborts without an out_valid;
  - clears the outputs;
  - restarts CLEAR; history contents are discarded.

## Test plan
- Reset, hold sample_valid = 0 → ready = 0 for 512 cycles then 1; coef_enb never asserts; all outputs 0.
- All coefficients = 0x7FFF, single sample 0x7FFF after clear → out_valid 516 cycles after accept; acc_out = 1073676289; filt_out = 32766.
- Coefficients = 0x7FFF, 512 consecutive samples of 0x7FFF → 512th result acc_out = 549722259968, filt_out = 32767 (saturated). Check coef_addrb sweeps 0..511 each pass.
- Coefficients = 0x8000 (−32768), 512 samples of 0x7FFF → filt_out = −32768 (saturated negative).
- Coef[k] = k+1, samples 1,0,0,… → the n-th output (0-based) has acc_out = n+1, confirming the history indexing (base − t) and wrap past address 511.
- sample_valid 100 cycles after an accept → overrun = 1 and stays set. The result equals that of the no-overrun run. Assert rrx_rst 200 cycles into the next RUN → no out_valid, overrun = 0, ready returns after 512 cycles.
